// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Pure declarations: no logic and no latency.
// No ports or flow control here; it is imported by uart_rx_ctrl and rx_bit_timer users.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    LOAD
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period counter: counts while enabled and ticks on the last cycle of a period.
// Latency: tick_o is combinational from the count; the count restarts the cycle after a tick.
// No backpressure; clear_i overrides en_i.
// Ports: clk, n_rst (async active-low), clear_i (force count to 0), en_i (count),
//        rollover_i (period length in cycles), tick_o (sample tick).
module rx_bit_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] rollover_i,
  output logic         tick_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Tick on the final cycle of the period, so a period of R cycles ticks at count R-1.
  assign tick_o = en_i && (count_q == (rollover_i - W'(1)));

  always_comb begin
    count_d = count_q;
    if (clear_i || tick_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: times start/data/parity/stop samples and drives shift/load strobes and error flags.
// Latency: with detect at cycle 0, start sample at HALF, data samples every CLKS_PER_BIT, load one cycle after the last stop sample.
// No backpressure: strobes are single-cycle pulses; start_bit_detected is ignored unless IDLE.
// Ports: clk, n_rst (async active-low), start_bit_detected, serial_in;
//        sbc_clear, shift_strobe, load_buffer (pulses); framing_error, parity_error (sticky); busy; break_detected.
// Optional build macro UART_RX_BREAK_DETECT_EN enables break-frame detection (otherwise break_detected is 0).
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start_bit_detected,
  input  logic serial_in,
  output logic sbc_clear,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic parity_error,
  output logic busy,
  output logic break_detected
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT + 1);
  localparam int CW   = 4;
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY_MODE == PAR_ODD);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic          pe_q, pe_d;
  logic          fe_q, fe_d;
  logic          tick;
  logic          timer_clear;
  logic [TW-1:0] rollover;
  logic          accept;
  logic          is_break;

  assign accept      = (state_q == IDLE) && start_bit_detected;
  // Timer is held at 0 while idle and during LOAD, so every state entry starts a fresh period.
  assign timer_clear = (state_q == IDLE) || (state_q == LOAD);
  assign rollover    = (state_q == START) ? TW'(HALF) : TW'(CLKS_PER_BIT);

  rx_bit_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear_i   (timer_clear),
    .en_i      (!timer_clear),
    .rollover_i(rollover),
    .tick_o    (tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start_bit_detected) state_d = START;
      START:  if (tick) state_d = serial_in ? IDLE : DATA;
      DATA:   if (tick && (bit_cnt_q == DATA_LAST))
                state_d = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick && (bit_cnt_q == STOP_LAST)) state_d = LOAD;
      LOAD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit counter is shared: counts data bits, then restarts to count stop bits.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    case (state_q)
      IDLE: if (start_bit_detected) begin
        bit_cnt_d = '0;
        par_d     = 1'b0;
        pe_d      = 1'b0;
        fe_d      = 1'b0;
      end
      DATA: if (tick) begin
        par_d     = par_q ^ serial_in;
        bit_cnt_d = (bit_cnt_q == DATA_LAST) ? '0 : bit_cnt_q + CW'(1);
      end
      PARITY: if (tick) begin
        // Even: total ones must be even; odd mode inverts the sense.
        pe_d = (par_q ^ serial_in) ^ ODD_PAR;
      end
      STOP: if (tick) begin
        if (!serial_in) fe_d = 1'b1;
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
      LOAD: bit_cnt_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  // Tracks whether every data, parity and first stop sample has been 0.
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (accept) begin
      zero_d = 1'b1;
    end else if (tick && ((state_q == DATA) || (state_q == PARITY) ||
                          ((state_q == STOP) && (bit_cnt_q == '0)))) begin
      zero_d = zero_q & ~serial_in;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign is_break = zero_q;
`else
  assign is_break = 1'b0;
`endif

  always_comb begin
    sbc_clear      = accept;
    shift_strobe   = (state_q == DATA) && tick;
    load_buffer    = (state_q == LOAD) && !fe_q && !is_break;
    break_detected = (state_q == LOAD) && is_break;
    framing_error  = fe_q;
    parity_error   = pe_q;
    busy           = (state_q != IDLE);
  end

endmodule
